pipe_stage_buf: RTL and testbench
=================================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 98; payload width in bits (PC, PC+4, instruction, branch-likely, BTB-hit).
REQ-002 SHALL have parameter DEPTH, default 2; entry count, legal range 1..8.
REQ-003 SHALL have parameter BUBBLE, default {32'h0, 32'h4, 32'h0, 2'b0}; payload presented while empty.
REQ-004 Reset and clock: reset is asynchronous and active-high; the clock is clk.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high; clears all state.
REQ-007 flush  input  1  discards all held entries.
REQ-008 in_valid  input  1  upstream offers in_data.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 in_ready  output  1  buffer accepts this cycle.
REQ-011 out_valid  output  1  out_data is a real entry.
REQ-012 out_data  output  DATA_W  head entry, or BUBBLE when empty.
REQ-013 out_ready  input  1  downstream consumes this cycle; low means stall.
REQ-014 count  output  clog2(DEPTH+1)  occupied entries.
REQ-015 stall_cnt  output  32  cycles with out_valid=1 and out_ready=0.
REQ-016 flush_cnt  output  32  flush cycles observed.

Function
REQ-017 Buffer SHALL be an in-order FIFO: push on in_valid&&in_ready; pop on out_valid&&out_ready.
REQ-018 in_ready SHALL be (count != DEPTH), registered-derived only, with no combinational path from out_ready.
REQ-019 out_valid SHALL be (count != 0); out_data SHALL be the head entry when valid and BUBBLE otherwise.
REQ-020 Latency: an entry pushed at edge N SHALL be visible on out_data after edge N. No same-cycle bypass.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, with the head advancing and the tail written.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH, including when DEPTH is not a power of two.
REQ-023 When flush=1, the next edge SHALL set count=0 and both pointers=0, ignoring any push or pop that cycle. flush has priority over everything except reset.
REQ-024 When full, in_valid SHALL be ignored and held data SHALL be unchanged. When empty, out_ready SHALL be ignored.
REQ-025 With DEPTH=1, throughput SHALL be one entry per two cycles. With DEPTH>=2, sustained throughput SHALL be one entry per cycle.
REQ-026 stall_cnt and flush_cnt SHALL saturate at 32'hFFFFFFFF.

Reset
REQ-027 Asserting reset at any time SHALL immediately set count=0, pointers=0, out_valid=0, out_data=BUBBLE, in_ready=1 (DEPTH>=1), stall_cnt=0, flush_cnt=0.
REQ-028 An entry in flight when reset asserts SHALL be lost. The first push after reset deassertion SHALL behave as a push into an empty buffer.
REQ-029 Storage array contents need not be reset. out_data SHALL never expose stale storage while empty.

Configuration
REQ-030 Macro PIPE_STAGE_PERF_EN defined: stall_cnt and flush_cnt SHALL count per REQ-015, REQ-016 and REQ-026.
REQ-031 Macro PIPE_STAGE_PERF_EN undefined: the ports SHALL remain and be tied to 32'h0, with no counter logic.

Structure
REQ-032 Package pipe_pkg SHALL hold the IF/ID payload field widths, field offsets, and the IF_ID_BUBBLE constant.
REQ-033 The counters SHALL live in one sub-module, pipe_stage_perf, instantiated only under PIPE_STAGE_PERF_EN.

Verification
REQ-034 DEPTH=2: push A, B on consecutive edges with out_ready=0 -> count=2, in_ready=0, out_data=A. A third push C is dropped.
REQ-035 DEPTH=2, count=1 (A), in_valid=1 (B), out_ready=1 for one edge -> count=1, out_data=B.
REQ-036 count=2, flush=1 together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_data=BUBBLE (PC+4 field = 32'h4).
REQ-037 DEPTH=3: stream 10 entries with random out_ready -> output order equals input order across pointer wrap.
REQ-038 Assert reset mid-stream at count=2 -> same cycle count=0, out_valid=0, in_ready=1. With PERF_EN, stall_cnt=0.
REQ-039 PERF_EN: hold out_ready=0 for 5 cycles with count=1, then flush twice -> stall_cnt=5, flush_cnt=2. Without the macro, both read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// IF/ID pipeline payload layout, bubble constant and perf counter sizing
// shared by the pipe_stage_buf slice.
package pipe_pkg;

    // Field widths of the IF/ID payload.
    localparam int unsigned PC_W     = 32;
    localparam int unsigned PC4_W    = 32;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned BL_W     = 1;
    localparam int unsigned BTB_W    = 1;
    localparam int unsigned IF_ID_W  = PC_W + PC4_W + INSTR_W + BL_W + BTB_W;

    // Field offsets, LSB first: {PC, PC+4, instruction, branch-likely, BTB-hit}.
    localparam int unsigned BTB_OFF   = 0;
    localparam int unsigned BL_OFF    = BTB_OFF + BTB_W;
    localparam int unsigned INSTR_OFF = BL_OFF + BL_W;
    localparam int unsigned PC4_OFF   = INSTR_OFF + INSTR_W;
    localparam int unsigned PC_OFF    = PC4_OFF + PC4_W;

    // Payload presented while the stage holds nothing: PC=0, PC+4=4, NOP.
    localparam logic [IF_ID_W-1:0] IF_ID_BUBBLE = {32'h0, 32'h4, 32'h0, 2'b0};

    // Performance counter sizing.
    localparam int unsigned        PERF_W   = 32;
    localparam logic [PERF_W-1:0]  PERF_MAX = '1;

endpackage

// File: rtl/pipe_stage_perf.sv
// Saturating stall and flush event counters for pipe_stage_buf.
// Instantiated only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_perf
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_evt,
    input  logic              flush_evt,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    logic [PERF_W-1:0] stall_q, stall_d;
    logic [PERF_W-1:0] flush_q, flush_d;

    // Next counter values: increment on event, hold at all-ones.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_evt && (stall_q != PERF_MAX)) stall_d = stall_q + 1'b1;
        if (flush_evt && (flush_q != PERF_MAX)) flush_d = flush_q + 1'b1;
    end

    // Counter registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// In-order FIFO pipeline stage buffer (IF/ID) with flush and bubble output.
// Optional perf counters (stall_cnt, flush_cnt) enabled by PIPE_STAGE_PERF_EN;
// without it both ports read zero.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W = IF_ID_W,
    parameter int unsigned       DEPTH  = 2,
    parameter logic [DATA_W-1:0] BUBBLE = IF_ID_BUBBLE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [31:0]                stall_cnt,
    output logic [31:0]                flush_cnt
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Array sized to the full pointer range so every pointer value is a legal
    // index; entries at or above DEPTH are never written.
    localparam int unsigned MEM_N = 1 << PTR_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [MEM_N];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop;

    // Handshakes depend only on registered occupancy.
    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : BUBBLE;
    assign count     = count_q;

    // Pointer and occupancy next state; flush overrides any push or pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
            if (push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage, not reset; out_data masks it with BUBBLE while empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= in_data;
    end

`ifdef PIPE_STAGE_PERF_EN
    pipe_stage_perf u_perf (
        .clk       (clk),
        .reset     (reset),
        .stall_evt (out_valid & ~out_ready),
        .flush_evt (flush),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf at DEPTH 2, 3 and 1.
// Reference model: a queue of payloads plus event counters.
module tb_pipe_stage_buf;

    localparam logic [97:0] BUB = {32'h0, 32'h4, 32'h0, 2'b0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // DEPTH=2 instance
    logic        a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
    logic [97:0] a_in_data = '0, a_out_data;
    logic [1:0]  a_count;
    logic [31:0] a_stall_cnt, a_flush_cnt;
    // DEPTH=3 instance
    logic        b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
    logic [97:0] b_in_data = '0, b_out_data;
    logic [1:0]  b_count;
    logic [31:0] b_stall_cnt, b_flush_cnt;
    // DEPTH=1 instance
    logic        c_flush = 0, c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0;
    logic [97:0] c_in_data = '0, c_out_data;
    logic [0:0]  c_count;
    logic [31:0] c_stall_cnt, c_flush_cnt;

    pipe_stage_buf #(.DEPTH(2)) u_d2 (
        .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_in_valid),
        .in_data(a_in_data), .in_ready(a_in_ready), .out_valid(a_out_valid),
        .out_data(a_out_data), .out_ready(a_out_ready), .count(a_count),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt));
    pipe_stage_buf #(.DEPTH(3)) u_d3 (
        .clk(clk), .reset(reset), .flush(b_flush), .in_valid(b_in_valid),
        .in_data(b_in_data), .in_ready(b_in_ready), .out_valid(b_out_valid),
        .out_data(b_out_data), .out_ready(b_out_ready), .count(b_count),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt));
    pipe_stage_buf #(.DEPTH(1)) u_d1 (
        .clk(clk), .reset(reset), .flush(c_flush), .in_valid(c_in_valid),
        .in_data(c_in_data), .in_ready(c_in_ready), .out_valid(c_out_valid),
        .out_data(c_out_data), .out_ready(c_out_ready), .count(c_count),
        .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt));

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model for the DEPTH=2 instance.
    logic [97:0] mq[$];
    logic [31:0] exp_stall = 0, exp_flush = 0;

    function automatic logic [97:0] rand_payload();
        logic [1:0] lo = 2'($urandom_range(0, 3));
        return {$urandom(), $urandom(), $urandom(), lo};
    endfunction

    function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef PIPE_STAGE_PERF_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    function automatic logic [97:0] head_exp();
        return (mq.size() != 0) ? mq[0] : BUB;
    endfunction

    // Drive one cycle into the DEPTH=2 instance and advance the model.
    task automatic a_cycle(input logic iv, input logic [97:0] d, input logic ordy, input logic fl);
        logic acc, pp;
        a_in_valid = iv; a_in_data = d; a_out_ready = ordy; a_flush = fl;
        acc = iv && (mq.size() < 2);
        pp  = (mq.size() != 0) && ordy;
        if ((mq.size() != 0) && !ordy && exp_stall != 32'hFFFF_FFFF) exp_stall++;
        if (fl && exp_flush != 32'hFFFF_FFFF) exp_flush++;
        if (fl) mq.delete();
        else begin
            if (pp) void'(mq.pop_front());
            if (acc) mq.push_back(d);
        end
        @(posedge clk); #1;
        a_in_valid = 0; a_out_ready = 0; a_flush = 0;
    endtask

    task automatic do_reset();
        a_in_valid = 0; a_out_ready = 0; a_flush = 0;
        b_in_valid = 0; b_out_ready = 0;
        c_in_valid = 0; c_out_ready = 0;
        @(negedge clk); reset = 1; #1; reset = 0;
        mq.delete(); exp_stall = 0; exp_flush = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (a_count !== 2'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", a_count); end
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", a_out_valid); end
        n_cmp++; if (a_out_data !== BUB) begin n_bad++; $display("FAIL reset_data: got %h expected %h", a_out_data, BUB); end
        n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
        n_cmp++; if (a_stall_cnt !== 32'h0 || a_flush_cnt !== 32'h0) begin
            n_bad++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", a_stall_cnt, a_flush_cnt); end
        @(negedge clk); reset = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_fill_full();
        logic [97:0] pa = rand_payload(), pb = rand_payload(), pc = rand_payload();
        do_reset();
        a_cycle(1, pa, 0, 0);
        n_cmp++; if (a_out_data !== pa) begin n_bad++; $display("FAIL push_latency: got %h expected %h", a_out_data, pa); end
        a_cycle(1, pb, 0, 0);
        n_cmp++; if (a_count !== 2'd2 || a_in_ready !== 1'b0) begin
            n_bad++; $display("FAIL full_state: got count=%0d rdy=%b expected 2/0", a_count, a_in_ready); end
        a_cycle(1, pc, 0, 0);
        n_cmp++; if (a_count !== 2'd2 || a_out_data !== pa) begin
            n_bad++; $display("FAIL full_drop: got count=%0d data=%h expected 2/%h", a_count, a_out_data, pa); end
        a_cycle(0, '0, 1, 0);
        n_cmp++; if (a_out_data !== pb) begin n_bad++; $display("FAIL pop_order: got %h expected %h", a_out_data, pb); end
        a_cycle(0, '0, 1, 0);
        n_cmp++; if (a_count !== 2'd0 || a_out_data !== BUB) begin
            n_bad++; $display("FAIL drain_bubble: got count=%0d data=%h expected 0/%h", a_count, a_out_data, BUB); end
        a_cycle(0, '0, 1, 0);
        n_cmp++; if (a_count !== 2'd0) begin n_bad++; $display("FAIL pop_empty: got %0d expected 0", a_count); end
    endtask

    task automatic test_push_pop();
        logic [97:0] pa = rand_payload(), pb = rand_payload();
        do_reset();
        a_cycle(1, pa, 0, 0);
        a_cycle(1, pb, 1, 0);
        n_cmp++; if (a_count !== 2'd1 || a_out_data !== pb) begin
            n_bad++; $display("FAIL push_pop: got count=%0d data=%h expected 1/%h", a_count, a_out_data, pb); end
    endtask

    task automatic test_flush();
        do_reset();
        a_cycle(1, rand_payload(), 0, 0);
        a_cycle(1, rand_payload(), 0, 0);
        a_cycle(1, rand_payload(), 1, 1);
        n_cmp++; if (a_count !== 2'd0 || a_out_valid !== 1'b0) begin
            n_bad++; $display("FAIL flush_state: got count=%0d valid=%b expected 0/0", a_count, a_out_valid); end
        n_cmp++; if (a_out_data[65:34] !== 32'h4 || a_out_data !== BUB) begin
            n_bad++; $display("FAIL flush_bubble: got %h expected %h", a_out_data, BUB); end
    endtask

    task automatic test_wrap_d3();
        logic [97:0] sd[10];
        int unsigned tx = 0, rx = 0;
        do_reset();
        foreach (sd[i]) sd[i] = rand_payload();
        for (int cyc = 0; cyc < 300 && rx < 10; cyc++) begin
            b_in_valid  = (tx < 10) && ($urandom_range(0, 3) != 0);
            b_in_data   = (tx < 10) ? sd[tx] : '0;
            b_out_ready = 1'($urandom_range(0, 1));
            if (b_out_valid && b_out_ready) begin
                n_cmp++; if (b_out_data !== sd[rx]) begin
                    n_bad++; $display("FAIL wrap_order[%0d]: got %h expected %h", rx, b_out_data, sd[rx]); end
                rx++;
            end
            if (b_in_valid && b_in_ready) tx++;
            @(posedge clk); #1;
            n_cmp++; if (int'(b_count) != int'(tx - rx)) begin
                n_bad++; $display("FAIL wrap_count: got %0d expected %0d", b_count, tx - rx); end
        end
        b_in_valid = 0; b_out_ready = 0;
        n_cmp++; if (rx != 10) begin n_bad++; $display("FAIL wrap_timeout: got %0d entries expected 10", rx); end
    endtask

    task automatic test_random_d2();
        do_reset();
        for (int i = 0; i < 200; i++) begin
            a_cycle(1'($urandom_range(0, 1)), rand_payload(), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 15) == 0);
            n_cmp++; if (a_count !== 2'(mq.size()) || a_out_data !== head_exp() ||
                         a_in_ready !== (mq.size() < 2) || a_out_valid !== (mq.size() != 0)) begin
                n_bad++; $display("FAIL rand[%0d]: got count=%0d data=%h expected count=%0d data=%h",
                                  i, a_count, a_out_data, mq.size(), head_exp()); end
        end
        n_cmp++; if (a_stall_cnt !== perf_exp(exp_stall) || a_flush_cnt !== perf_exp(exp_flush)) begin
            n_bad++; $display("FAIL rand_perf: got %0d/%0d expected %0d/%0d",
                              a_stall_cnt, a_flush_cnt, perf_exp(exp_stall), perf_exp(exp_flush)); end
    endtask

    task automatic test_back_to_back();
        int unsigned n1 = 0, n2 = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            c_in_valid = 1; c_out_ready = 1; c_in_data = rand_payload();
            if (c_in_ready) n1++;
            if (a_in_ready) n2++;
            a_cycle(1, rand_payload(), 1, 0);
        end
        c_in_valid = 0; c_out_ready = 0;
        n_cmp++; if (n1 != 10) begin n_bad++; $display("FAIL thru_d1: got %0d expected 10", n1); end
        n_cmp++; if (n2 != 20) begin n_bad++; $display("FAIL thru_d2: got %0d expected 20", n2); end
    endtask

    task automatic test_reset_mid();
        logic [97:0] pa = rand_payload();
        do_reset();
        a_cycle(1, rand_payload(), 0, 0);
        a_cycle(1, rand_payload(), 0, 0);
        #2; reset = 1; #1;
        n_cmp++; if (a_count !== 2'd0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_mid: got count=%0d valid=%b rdy=%b expected 0/0/1",
                              a_count, a_out_valid, a_in_ready); end
        n_cmp++; if (a_stall_cnt !== 32'h0) begin n_bad++; $display("FAIL reset_mid_stall: got %0d expected 0", a_stall_cnt); end
        #1; reset = 0;
        mq.delete(); exp_stall = 0; exp_flush = 0;
        @(posedge clk); #1;
        a_cycle(1, pa, 0, 0);
        n_cmp++; if (a_count !== 2'd1 || a_out_data !== pa) begin
            n_bad++; $display("FAIL post_reset_push: got count=%0d data=%h expected 1/%h", a_count, a_out_data, pa); end
    endtask

    task automatic test_perf();
        do_reset();
        a_cycle(1, rand_payload(), 0, 0);
        for (int i = 0; i < 5; i++) a_cycle(0, '0, 0, 0);
        a_cycle(0, '0, 1, 1);
        a_cycle(0, '0, 1, 1);
        n_cmp++; if (a_stall_cnt !== perf_exp(32'd5)) begin
            n_bad++; $display("FAIL perf_stall: got %0d expected %0d", a_stall_cnt, perf_exp(32'd5)); end
        n_cmp++; if (a_flush_cnt !== perf_exp(32'd2)) begin
            n_bad++; $display("FAIL perf_flush: got %0d expected %0d", a_flush_cnt, perf_exp(32'd2)); end
    endtask

    initial begin
        test_reset();
        test_fill_full();
        test_push_pop();
        test_flush();
        test_wrap_d3();
        test_random_d2();
        test_back_to_back();
        test_reset_mid();
        test_perf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
